// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl_pkg
// Brief    : Shared types, funct3 codes and size-mask helper for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } e_lsu_state;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    function automatic logic [7:0] size_mask(input logic [1:0] i_size);
        case (i_size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational lane steering, load extension and fault detection.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_is_store,
    input  logic [2:0]      i_funct3,
    input  logic [2:0]      i_ea_lo,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_rdata,
    output logic [7:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_ldata,
    output logic            o_misaligned,
    output logic            o_illegal
);

    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_rshift;
    logic            w_mis_raw;

    assign w_shamt = {i_ea_lo, 3'b000};

    always_comb begin
        o_illegal = i_is_store ? i_funct3[2] : (i_funct3 == 3'b111);

        case (i_funct3[1:0])
            2'd0:    w_mis_raw = 1'b0;
            2'd1:    w_mis_raw = i_ea_lo[0];
            2'd2:    w_mis_raw = |i_ea_lo[1:0];
            default: w_mis_raw = |i_ea_lo;
        endcase
        // An illegal encoding is reported alone, never together with misalignment.
        o_misaligned = w_mis_raw & ~o_illegal;

        o_be    = size_mask(i_funct3[1:0]) << i_ea_lo;
        o_wdata = i_rs2 << w_shamt;

        w_rshift = i_rdata >> w_shamt;
        case (i_funct3)
            LSU_B:   o_ldata = {{(XLEN-8){w_rshift[7]}},   w_rshift[7:0]};
            LSU_H:   o_ldata = {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
            LSU_W:   o_ldata = {{(XLEN-32){w_rshift[31]}}, w_rshift[31:0]};
            LSU_D:   o_ldata = w_rshift;
            LSU_BU:  o_ldata = {{(XLEN-8){1'b0}},  w_rshift[7:0]};
            LSU_HU:  o_ldata = {{(XLEN-16){1'b0}}, w_rshift[15:0]};
            LSU_WU:  o_ldata = {{(XLEN-32){1'b0}}, w_rshift[31:0]};
            default: o_ldata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Single-outstanding load/store sequencer, execute -> data memory.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic [XLEN-1:0]   req_imm,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic [4:0]        rsp_rd,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_misaligned,
    output logic              rsp_illegal
);

    e_lsu_state        r_state;
    e_lsu_state        w_next;

    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_rs2;
    logic [4:0]        r_rd;
    logic [ADDR_W-1:0] r_ea;
    logic [XLEN-1:0]   r_rsp_data;
    logic              r_misaligned;
    logic              r_illegal;

    logic [XLEN-1:0]   w_ea_full;
    logic [ADDR_W-1:0] w_ea;
    logic              w_idle;
    logic              w_issue;
    logic              w_accept;
    logic              w_al_store;
    logic [2:0]        w_al_funct3;
    logic [2:0]        w_al_ea_lo;
    logic [XLEN-1:0]   w_al_rs2;
    logic [7:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ldata;
    logic              w_misaligned;
    logic              w_illegal;
    logic              w_fault;

    assign w_ea_full = req_rs1 + req_imm;
    assign w_ea      = w_ea_full[ADDR_W-1:0];
    assign w_idle    = (r_state == S_IDLE);
    assign w_issue   = (r_state == S_ISSUE);
    assign w_accept  = w_idle & req_valid;

    // In IDLE the aligner judges the incoming op; afterwards it works on the latched op.
    assign w_al_store  = w_idle ? req_is_store : r_is_store;
    assign w_al_funct3 = w_idle ? req_funct3   : r_funct3;
    assign w_al_ea_lo  = w_idle ? w_ea[2:0]    : r_ea[2:0];
    assign w_al_rs2    = w_idle ? req_rs2      : r_rs2;
    assign w_fault     = w_misaligned | w_illegal;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_is_store   (w_al_store),
        .i_funct3     (w_al_funct3),
        .i_ea_lo      (w_al_ea_lo),
        .i_rs2        (w_al_rs2),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_ldata      (w_ldata),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_fault ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    w_next = r_is_store ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_rs2        <= '0;
            r_rd         <= 5'd0;
            r_ea         <= '0;
            r_rsp_data   <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (w_accept) begin
            r_is_store   <= req_is_store;
            r_funct3     <= req_funct3;
            r_rs2        <= req_rs2;
            r_rd         <= req_rd;
            r_ea         <= w_ea;
            r_rsp_data   <= '0;
            r_misaligned <= w_misaligned;
            r_illegal    <= w_illegal;
        end else if ((r_state == S_WAIT) && mem_rvalid) begin
            r_rsp_data   <= w_ldata;
        end
    end

    // Memory-side fields are quiet outside ISSUE; byte enables only mean something for stores.
    assign mem_we    = w_issue & r_is_store;
    assign mem_addr  = w_issue ? {r_ea[ADDR_W-1:3], 3'b000} : '0;
    assign mem_be    = (w_issue & r_is_store) ? w_be : 8'h00;
    assign mem_wdata = (w_issue & r_is_store) ? w_wdata : '0;

    assign rsp_data       = r_rsp_data;
    assign rsp_rd         = r_rd;
    assign rsp_addr       = r_ea;
    assign rsp_misaligned = r_misaligned;
    assign rsp_illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Directed plus random load/store checks of lsu_ctrl against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_ctrl;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_is_store = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [XLEN-1:0]   req_rs1 = '0;
    logic [XLEN-1:0]   req_rs2 = '0;
    logic [XLEN-1:0]   req_imm = '0;
    logic [4:0]        req_rd = 5'd0;
    logic              mem_req;
    logic              mem_gnt = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rvalid = 1'b0;
    logic [XLEN-1:0]   mem_rdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [XLEN-1:0]   rsp_data;
    logic [4:0]        rsp_rd;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_misaligned;
    logic              rsp_illegal;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(
        .ADDR_W (ADDR_W),
        .XLEN   (XLEN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .req_imm        (req_imm),
        .req_rd         (req_rd),
        .mem_req        (mem_req),
        .mem_gnt        (mem_gnt),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_rd         (rsp_rd),
        .rsp_addr       (rsp_addr),
        .rsp_misaligned (rsp_misaligned),
        .rsp_illegal    (rsp_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op through accept, issue, wait and response with the given stall counts.
    task automatic do_op(input logic st, input logic [2:0] f3,
                         input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                         input logic [4:0] rd, input logic [63:0] rdata,
                         input int gd, input int rvd, input int rdyd,
                         output logic [63:0] got);
        logic [63:0] ea, wmask, vmask, val, exp_data, exp_addr, exp_wdata;
        logic [7:0]  exp_be;
        int          off, nbytes;
        logic        ill, mis, fault;

        ea       = rs1 + imm;
        off      = int'(ea[2:0]);
        nbytes   = 1 << int'(f3[1:0]);
        ill      = st ? (f3 > 3'd3) : (f3 == 3'd7);
        mis      = !ill && ((ea % 64'(nbytes)) != 64'd0);
        fault    = ill || mis;
        exp_be   = st ? 8'(((1 << nbytes) - 1) << off) : 8'h00;
        wmask    = '0;
        for (int i = 0; i < 8; i++) begin
            if (exp_be[i]) wmask[8*i +: 8] = 8'hFF;
        end
        exp_wdata = (rs2 << (8 * off)) & wmask;
        vmask    = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
        val      = (rdata >> (8 * off)) & vmask;
        if ((f3 < 3'd4) && val[8*nbytes-1]) val = val | ~vmask;
        exp_data = (st || fault) ? 64'd0 : val;
        exp_addr = ea & ~64'd7;
        got      = '0;

        chk("idle_ready", 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_rs1      = rs1;
        req_rs2      = rs2;
        req_imm      = imm;
        req_rd       = rd;
        tick();
        req_valid    = 1'b0;

        if (!fault) begin
            for (int c = 0; c <= gd; c++) begin
                chk("issue_ctl", 64'({mem_req, mem_we, rsp_valid, req_ready}), 64'({1'b1, st, 2'b00}));
                chk("issue_addr", mem_addr, exp_addr);
                chk("issue_be", 64'(mem_be), 64'(exp_be));
                chk("issue_wdata", mem_wdata & wmask, exp_wdata);
                if (c == gd) mem_gnt = 1'b1;
                tick();
            end
            mem_gnt = 1'b0;
            if (!st) begin
                for (int c = 0; c <= rvd; c++) begin
                    chk("wait_ctl", 64'({mem_req, rsp_valid, req_ready}), 64'd0);
                    if (c == rvd) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata;
                    end
                    tick();
                end
                mem_rvalid = 1'b0;
                mem_rdata  = {$urandom, $urandom};
            end
        end

        for (int c = 0; c <= rdyd; c++) begin
            if (c == 0) got = rsp_data;
            chk("rsp_ctl", 64'({rsp_valid, req_ready, mem_req, rsp_misaligned, rsp_illegal}),
                64'({3'b100, mis, ill}));
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_addr", rsp_addr, ea);
            chk("rsp_rd", 64'(rsp_rd), 64'(rd));
            if (c == rdyd) rsp_ready = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
        chk("post_rsp", 64'({rsp_valid, req_ready}), 64'(2'b01));
    endtask

    initial begin
        logic [63:0] got;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] rs1, rs2, imm;
        logic [31:0] r;
        int          sh;

        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_mem", 64'({mem_req, mem_we, mem_be}), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_rsp_ctl", 64'({rsp_valid, rsp_misaligned, rsp_illegal, rsp_rd}), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_addr", rsp_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(1'b0, 3'b011, 64'h1000, 64'd0, 64'd8, 5'd3, 64'h8877665544332211, 0, 0, 0, got);
        chk("t1_ld", got, 64'h8877665544332211);
        do_op(1'b0, 3'b000, 64'h2000, 64'd0, 64'd3, 5'd4, 64'h0000000080000000, 0, 0, 0, got);
        chk("t2_lb", got, 64'hFFFFFFFFFFFFFF80);
        do_op(1'b0, 3'b100, 64'h2000, 64'd0, 64'd3, 5'd5, 64'h0000000080000000, 0, 0, 0, got);
        chk("t2_lbu", got, 64'h80);
        do_op(1'b1, 3'b001, 64'h3000, 64'hABCD, 64'd2, 5'd6, 64'd0, 0, 0, 0, got);
        chk("t3_sh_data", got, 64'd0);
        do_op(1'b0, 3'b010, 64'h4000, 64'd0, 64'd2, 5'd7, 64'hFFFF, 0, 0, 0, got);
        do_op(1'b1, 3'b101, 64'h5000, 64'h1234, 64'd0, 5'd8, 64'd0, 0, 0, 0, got);
        do_op(1'b0, 3'b111, 64'h5001, 64'd0, 64'd0, 5'd9, 64'd0, 0, 0, 1, got);
        do_op(1'b0, 3'b110, 64'h7000, 64'd0, 64'd4, 5'd10, 64'hF0E0D0C0B0A09080, 3, 2, 2, got);
        chk("t5_lwu", got, 64'h00000000F0E0D0C0);
        do_op(1'b1, 3'b011, 64'h7FF8, 64'h1122334455667788, 64'd8, 5'd11, 64'd0, 3, 0, 2, got);

        // Reset lands while a load waits for data; the late rvalid must be ignored.
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_funct3   = 3'b011;
        req_rs1      = 64'h6000;
        req_imm      = 64'd0;
        req_rd       = 5'd9;
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt   = 1'b0;
        chk("rst_wait_ctl", 64'({mem_req, rsp_valid, req_ready}), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_abort_ctl", 64'({mem_req, mem_we, rsp_valid, rsp_misaligned, rsp_illegal, rsp_rd}), 64'd0);
        chk("rst_abort_data", rsp_data, 64'd0);
        chk("rst_abort_addr", rsp_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ctl", 64'({req_ready, rsp_valid, mem_req}), 64'(3'b100));
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0123456789ABCDEF;
        tick();
        mem_rvalid = 1'b0;
        chk("post_rst_rvalid", 64'({req_ready, rsp_valid, mem_req}), 64'(3'b100));
        chk("post_rst_data", rsp_data, 64'd0);

        for (int n = 0; n < 60; n++) begin
            r   = $urandom;
            st  = r[0];
            f3  = r[3:1];
            rs1 = {$urandom, $urandom};
            rs2 = {$urandom, $urandom};
            imm = {{52{r[15]}}, r[15:4]};
            sh  = int'(f3[1:0]);
            if (r[17:16] != 2'b00) begin
                rs1 = rs1 & ~64'd7;
                imm = (imm & ~64'd7) | 64'((($urandom % 8) >> sh) << sh);
            end
            do_op(st, f3, rs1, rs2, imm, r[22:18], {$urandom, $urandom},
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Sequencer between the execute stage and the data-memory port for RV64 loads and stores.
- Accepts one memory op at a time and forms EA = rs1 + imm.
- Checks alignment and funct3, then drives a req/gnt/rvalid memory handshake.
- Produces the lane-aligned store strobes/data and the sign/zero-extended load result.
- Returns a single response to writeback. Single outstanding transaction, no buffering beyond one op.

Parameters:
- ADDR_W, 64, effective/memory address width.
- XLEN, 64, data width; memory port is XLEN wide with XLEN/8 byte enables.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req_valid  in  1  execute offers an op
- req_ready  out  1  controller can accept
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV64 width/sign code
- req_rs1  in  XLEN  base
- req_rs2  in  XLEN  store data
- req_imm  in  XLEN  sign-extended offset
- req_rd  in  5  load destination
- mem_req  out  1  request to memory
- mem_gnt  in  1  memory accepts request
- mem_we  out  1  write
- mem_addr  out  ADDR_W  EA with [2:0] forced to 0
- mem_be  out  8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  aligned doubleword
- rsp_valid  out  1  result available
- rsp_ready  in  1  writeback takes result
- rsp_data  out  XLEN  load value; 0 for stores and faults
- rsp_rd  out  5  latched rd
- rsp_addr  out  ADDR_W  full EA, also reported on fault
- rsp_misaligned  out  1  alignment fault
- rsp_illegal  out  1  bad funct3

Behaviour:
- Reset: state = IDLE; all outputs and latched fields are 0, including mem_req and rsp_valid.
  - Reset asserted mid-transaction aborts it immediately. The pending response is dropped.
  - Memory is reset on the same rst_n.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1 only in IDLE.
  - On req_valid && req_ready, latch the op and EA = rs1 + imm, wrapping modulo 2^64.
  - If a fault is detected, go to RESP with no memory access. Otherwise go to ISSUE.
- Fault rules:
  - Misaligned when: H/HU and EA[0] != 0; W/WU and EA[1:0] != 0; D and EA[2:0] != 0.
  - Illegal when: load funct3 = 3'b111; store funct3 > 3'b011.
  - If both apply, illegal wins and rsp_misaligned = 0.
- ISSUE:
  - mem_req = 1. mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_gnt.
  - On gnt, a store goes to RESP and a load goes to WAIT.
  - mem_rvalid is ignored in ISSUE; memory never returns rvalid in the gnt cycle.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid, extract byte lanes EA[2:0] from mem_rdata.
  - Sign-extend for LB/LH/LW/LD; zero-extend for LBU/LHU/LWU.
  - Register the value into rsp_data and go to RESP.
- RESP:
  - rsp_valid = 1 and all rsp_* are held stable until rsp_ready.
  - Handshake cycle returns to IDLE; rsp_valid drops the next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- Store lanes:
  - mem_be = size mask (1/3/F/FF hex) << EA[2:0].
  - mem_wdata = rs2 << (8*EA[2:0]); upper bits truncated.
  - Lanes outside be are don't-care but must be deterministic.
- Latency: with gnt in the first ISSUE cycle and rvalid in the first WAIT cycle:
  - load: accept at cycle 0, rsp_valid at cycle 3;
  - store: rsp_valid at cycle 2;
  - fault: rsp_valid at cycle 1.
- Stall tolerance: gnt, rvalid and rsp_ready may each be held low for any number of cycles; no timeout.

Decomposition:
- types package:
  - e_lsu_state enum;
  - funct3 constants LSU_B, LSU_H, LSU_W, LSU_D, LSU_BU, LSU_HU, LSU_WU;
  - size-mask function.
- Sub-module lsu_align, purely combinational:
  - inputs: funct3, EA[2:0], rs2, mem_rdata;
  - outputs: be, wdata, extended load data, misaligned, illegal.
- The FSM and latches stay in lsu_ctrl.

Test Plan:
1. LD: rs1=0x1000, imm=8, rdata=0x8877665544332211, gnt/rvalid immediate -> mem_addr=0x1008, be=0x00, rsp_data=0x8877665544332211 at cycle 3.
2. LB vs LBU: EA=0x2003, rdata byte3=0x80 -> LB gives rsp_data=0xFFFFFFFFFFFFFF80; LBU gives 0x80.
3. SH: EA=0x3002, rs2=0xABCD -> mem_we=1, be=0x0C, wdata[31:16]=0xABCD, rsp_valid at cycle 2, rsp_data=0.
4. LW at EA=0x4002 -> no mem_req ever, rsp_misaligned=1, rsp_addr=0x4002, rsp_valid at cycle 1. Store funct3=3'b101 -> rsp_illegal=1.
5. Backpressure: gnt delayed 3 cycles and rsp_ready delayed 2 cycles -> mem_* and rsp_* stable throughout; req_ready=0 until return to IDLE.
6. Reset in WAIT, then rvalid after deassert -> outputs 0, state IDLE, no rsp_valid, req_ready=1 once reset deasserts.
